div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 startDiv  input  1  level request from decode; held high by pipeline stall until ready is seen.
REQ-005 Sign  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled at accept only.
REQ-006 annul  input  1  cancels the accepted or in-flight divide.
REQ-007 opA  input  32  dividend (rs); sampled at accept only.
REQ-008 opB  input  32  divisor (rt); sampled at accept only.
REQ-009 result  output  64  [63:32] remainder (to HI), [31:0] quotient (to LO).
REQ-010 ready  output  1  result valid.
REQ-011 busy  output  1  iteration in progress; drives pipeline stall.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE.
REQ-013 IDLE -> BUSY on an edge with startDiv=1, annul=0, opB!=0: latch |opA|, |opB| (two's-complement magnitude when Sign=1, raw otherwise), the quotient sign (opA[31]^opB[31])&Sign and the remainder sign opA[31]&Sign; clear the 6-bit iteration counter.
REQ-014 IDLE -> DONE on an edge with startDiv=1, annul=0, opB==0: result SHALL be 64'h0.
REQ-015 BUSY SHALL perform one restoring shift-subtract step per cycle, MSB first, over 32 cycles; counter increments once per step.
REQ-016 On the edge completing step 32, the FSM SHALL enter DONE and register the sign-corrected quotient and remainder into result.
REQ-017 Latency: ready SHALL first be high in the cycle after accept edge k+32 (33 cycles after accept); division by zero: the cycle after the accept edge.
REQ-018 ready SHALL be 1 exactly while in DONE; result SHALL be stable while ready=1.
REQ-019 DONE -> IDLE on an edge with startDiv=0; DONE SHALL hold while startDiv=1.
REQ-020 Back-to-back divides therefore require startDiv low for at least one cycle between them.
REQ-021 busy SHALL be 1 exactly while in BUSY.
REQ-022 annul=1 in BUSY or DONE SHALL force IDLE on the next edge with ready never asserted for the cancelled operation; result keeps its previous value.
REQ-023 annul=1 in IDLE SHALL suppress accept regardless of startDiv.
REQ-024 Changes on opA, opB and Sign after accept SHALL have no effect on the operation.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 (wrap) and remainder 0.
REQ-026 Remainder sign SHALL follow the dividend; quotient SHALL truncate toward zero.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, counter 0, result 64'h0, ready 0, busy 0, regardless of state, including mid-BUSY.
REQ-028 rst SHALL take priority over startDiv and annul.

Structure
REQ-029 A shared package SHALL hold the state encoding (2-bit typedef) and constants DIV_WIDTH=32 and DIV_ITERS=32.
REQ-030 div_unit SHALL be a single module with no sub-modules; the shift-subtract step and the sign fix-up are inline combinational logic.

Verification
REQ-031 Signed: opA=0xFFFFFFF9 (-7), opB=2 -> result=0xFFFFFFFF_FFFFFFFD, ready exactly 33 cycles after accept, busy high for 32 cycles.
REQ-032 Unsigned: opA=100, opB=7 -> result=0x00000002_0000000E; same opA/opB with Sign=1 gives the same result.
REQ-033 Divide by zero: opB=0 -> result=0, ready the cycle after accept, busy never high.
REQ-034 Overflow/extreme cases: signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000; unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
REQ-035 annul pulse after step 10 -> IDLE next cycle, ready stays 0; a following request 100/7 completes correctly.
REQ-036 rst asserted after step 20 -> all outputs 0 next cycle; holding startDiv in DONE keeps ready=1, and dropping it returns the FSM to IDLE.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
// Holds the FSM state encoding, datapath width and iteration count, and a
// helper that returns the operand magnitude for signed or unsigned divides.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Two's-complement magnitude when the operation is signed and the
    // operand is negative; the raw value otherwise. The magnitude of
    // 0x80000000 wraps to 0x80000000, which is the correct unsigned value.
    function automatic logic [DIV_WIDTH-1:0] op_mag(input logic [DIV_WIDTH-1:0] v,
                                                    input logic is_signed);
        return (is_signed && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV / DIVU), one quotient bit per cycle.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   startDiv  level request, held until ready is seen
//   Sign      1 = signed divide, 0 = unsigned (sampled at accept)
//   annul     cancels an accepted or in-flight divide
//   opA, opB  dividend / divisor (sampled at accept)
//   result    {remainder, quotient}
//   ready     result valid (DONE state)
//   busy      iteration in progress (BUSY state)
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        startDiv,
    input  logic        Sign,
    input  logic        annul,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [63:0] result,
    output logic        ready,
    output logic        busy
);

    localparam logic [5:0] LAST_STEP = 6'(DIV_ITERS - 1);

    div_state_t state_reg, state_next;

    logic [5:0]           cnt_reg;
    logic [DIV_WIDTH-1:0] divisor_reg;
    // Holds the remaining dividend bits in the top and the developing
    // quotient bits in the bottom; one bit moves across per step.
    logic [DIV_WIDTH-1:0] quo_reg;
    logic [DIV_WIDTH-1:0] rem_reg;
    logic                 q_neg_reg;
    logic                 r_neg_reg;
    logic [63:0]          result_reg;

    logic                 accept;
    logic                 last_step;
    logic [DIV_WIDTH:0]   rem_shift;
    logic [DIV_WIDTH:0]   diff;
    logic                 take;
    logic [DIV_WIDTH-1:0] rem_step;
    logic [DIV_WIDTH-1:0] quo_step;
    logic [DIV_WIDTH-1:0] quo_fix;
    logic [DIV_WIDTH-1:0] rem_fix;

    assign accept    = (state_reg == ST_IDLE) && startDiv && !annul;
    assign last_step = (cnt_reg == LAST_STEP);

    // Restoring step. The partial remainder is always below the divisor, so
    // the shifted value is below 2*divisor and fits 33 bits; bit 32 of the
    // difference is therefore a clean borrow flag.
    always_comb begin
        rem_shift = {rem_reg, quo_reg[DIV_WIDTH-1]};
        diff      = rem_shift - {1'b0, divisor_reg};
        take      = ~diff[DIV_WIDTH];
        rem_step  = take ? diff[DIV_WIDTH-1:0] : rem_shift[DIV_WIDTH-1:0];
        quo_step  = {quo_reg[DIV_WIDTH-2:0], take};
        quo_fix   = q_neg_reg ? (~quo_step + 1'b1) : quo_step;
        rem_fix   = r_neg_reg ? (~rem_step + 1'b1) : rem_step;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept)
                    state_next = (opB == '0) ? ST_DONE : ST_BUSY;
            end
            ST_BUSY: begin
                if (annul)
                    state_next = ST_IDLE;
                else if (last_step)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                if (annul || !startDiv)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            divisor_reg <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            result_reg  <= '0;
        end else if (accept) begin
            cnt_reg     <= '0;
            divisor_reg <= op_mag(opB, Sign);
            quo_reg     <= op_mag(opA, Sign);
            rem_reg     <= '0;
            q_neg_reg   <= (opA[31] ^ opB[31]) & Sign;
            r_neg_reg   <= opA[31] & Sign;
            if (opB == '0)
                result_reg <= '0;
        end else if (state_reg == ST_BUSY && !annul) begin
            cnt_reg <= cnt_reg + 6'd1;
            quo_reg <= quo_step;
            rem_reg <= rem_step;
            if (last_step)
                result_reg <= {rem_fix, quo_fix};
        end
    end

    assign result = result_reg;
    assign ready  = (state_reg == ST_DONE);
    assign busy   = (state_reg == ST_BUSY);

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: latency, signed/unsigned results,
// divide by zero, extreme operands, annul and reset behaviour.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        startDiv;
    logic        Sign;
    logic        annul;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int lat;
    int busy_n;

    div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .startDiv (startDiv),
        .Sign     (Sign),
        .annul    (annul),
        .opA      (opA),
        .opB      (opB),
        .result   (result),
        .ready    (ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue a divide at a falling edge, scramble operands right after the
    // accept edge, and measure cycles until ready plus cycles with busy high.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output int l, output int bn);
        startDiv = 1'b1;
        Sign     = s;
        opA      = a;
        opB      = b;
        l  = -1;
        bn = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                opA  = ~a;
                opB  = 32'h3;
                Sign = ~s;
            end
            if (busy) bn++;
            if (ready) begin
                l = n;
                break;
            end
        end
    endtask

    // Hold startDiv in DONE for two cycles, then release and expect IDLE.
    task automatic hold_release(input string tag, input logic [63:0] exp);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check({tag, "_hold_ready"}, 64'(ready), 64'd1);
            check({tag, "_hold_result"}, result, exp);
        end
        startDiv = 1'b0;
        @(negedge clk);
        check({tag, "_release_ready"}, 64'(ready), 64'd0);
        check({tag, "_release_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; startDiv = 1'b0; Sign = 1'b0; annul = 1'b0;
        opA = '0; opB = '0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 64'h0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Signed -7 / 2 = -3 rem -1
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, busy_n);
        check("s_m7_2_latency", 64'(lat), 64'd33);
        check("s_m7_2_busy_cycles", 64'(busy_n), 64'd32);
        check("s_m7_2_result", result, 64'hFFFFFFFF_FFFFFFFD);
        hold_release("s_m7_2", 64'hFFFFFFFF_FFFFFFFD);

        // Unsigned 100 / 7 = 14 rem 2
        run_div(1'b0, 32'd100, 32'd7, lat, busy_n);
        check("u_100_7_latency", 64'(lat), 64'd33);
        check("u_100_7_result", result, 64'h00000002_0000000E);
        hold_release("u_100_7", 64'h00000002_0000000E);

        // Signed 100 / 7 gives the same result
        run_div(1'b1, 32'd100, 32'd7, lat, busy_n);
        check("s_100_7_result", result, 64'h00000002_0000000E);
        hold_release("s_100_7", 64'h00000002_0000000E);

        // Signed 7 / -2 = -3 rem 1 (remainder follows the dividend)
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, lat, busy_n);
        check("s_7_m2_result", result, 64'h00000001_FFFFFFFD);
        hold_release("s_7_m2", 64'h00000001_FFFFFFFD);

        // Divide by zero
        run_div(1'b1, 32'h12345678, 32'd0, lat, busy_n);
        check("div0_latency", 64'(lat), 64'd1);
        check("div0_busy_cycles", 64'(busy_n), 64'd0);
        check("div0_result", result, 64'h0);
        hold_release("div0", 64'h0);

        // Signed overflow wraps
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, busy_n);
        check("s_ovf_latency", 64'(lat), 64'd33);
        check("s_ovf_result", result, 64'h00000000_80000000);
        hold_release("s_ovf", 64'h00000000_80000000);

        // Unsigned max / 1
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, lat, busy_n);
        check("u_max_1_result", result, 64'h00000000_FFFFFFFF);
        hold_release("u_max_1", 64'h00000000_FFFFFFFF);

        // annul in IDLE suppresses accept
        startDiv = 1'b1; annul = 1'b1; Sign = 1'b0; opA = 32'd50; opB = 32'd5;
        repeat (3) begin
            @(negedge clk);
            check("idle_annul_busy", 64'(busy), 64'd0);
            check("idle_annul_ready", 64'(ready), 64'd0);
        end
        startDiv = 1'b0; annul = 1'b0;
        @(negedge clk);

        // annul after step 10
        startDiv = 1'b1; Sign = 1'b0; opA = 32'd1000; opB = 32'd3;
        repeat (11) @(negedge clk);
        check("annul_pre_busy", 64'(busy), 64'd1);
        annul = 1'b1; startDiv = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        check("annul_busy", 64'(busy), 64'd0);
        check("annul_ready", 64'(ready), 64'd0);
        check("annul_result_kept", result, 64'h00000000_FFFFFFFF);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (ready) seen++;
            end
            check("annul_ready_never", 64'(seen), 64'd0);
        end
        run_div(1'b0, 32'd100, 32'd7, lat, busy_n);
        check("post_annul_latency", 64'(lat), 64'd33);
        check("post_annul_result", result, 64'h00000002_0000000E);
        hold_release("post_annul", 64'h00000002_0000000E);

        // reset after step 20
        startDiv = 1'b1; Sign = 1'b1; opA = 32'hFFFFFFF9; opB = 32'd2;
        repeat (21) @(negedge clk);
        check("rst_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1; startDiv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_result", result, 64'h0);
        check("rst_mid_ready", 64'(ready), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);

        // Operation after reset still works
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, busy_n);
        check("post_rst_latency", 64'(lat), 64'd33);
        check("post_rst_result", result, 64'hFFFFFFFF_FFFFFFFD);
        hold_release("post_rst", 64'hFFFFFFFF_FFFFFFFD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
